sd_card_mem_arbiter: RTL and testbench



---
 rtl/sd_card_mem_pkg.sv | 18 +
 rtl/sd_card_rr_picker.sv | 29 ++
 rtl/sd_card_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_sd_card_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_card_mem_pkg.sv
// Shared constants and types for the SD_CARD buffer RAM arbiter.
package sd_card_mem_pkg;

    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = 4;
    localparam int unsigned MEM_DEPTH = 75000;

    // Data returned for reads rejected by the optional address range check
    localparam logic [31:0] RANGE_ERR_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RD
    } state_e;

endpackage

// File: rtl/sd_card_rr_picker.sv
// Combinational round-robin picker: searches last_grant+1, last_grant+2, ... with wrap.
module sd_card_rr_picker #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       valid
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int unsigned idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = 32'(last_grant) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid && req[idx[IDX_W-1:0]]) begin
                grant[idx[IDX_W-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_card_mem_arbiter.sv
// Round-robin arbiter sharing the single-port SD_CARD buffer RAM between NUM_REQ masters.
// Optional macro SD_MEM_RANGE_CHECK_EN blocks out-of-range accesses and adds req_error.
module sd_card_mem_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ADDR_W    = sd_card_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W    = sd_card_mem_pkg::DATA_W,
    parameter int unsigned MEM_DEPTH = sd_card_mem_pkg::MEM_DEPTH
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0]                req_address,
    input  logic [NUM_REQ*sd_card_mem_pkg::BE_W-1:0] req_byteenable,
    input  logic [NUM_REQ-1:0]                       req_read,
    input  logic [NUM_REQ-1:0]                       req_write,
    input  logic [NUM_REQ*DATA_W-1:0]                req_writedata,
    output logic [NUM_REQ-1:0]                       req_waitrequest,
    output logic [DATA_W-1:0]                        req_readdata,
    output logic [NUM_REQ-1:0]                       req_readdatavalid,
`ifdef SD_MEM_RANGE_CHECK_EN
    output logic [NUM_REQ-1:0]                       req_error,
`endif
    output logic [ADDR_W-1:0]                        mem_address,
    output logic [sd_card_mem_pkg::BE_W-1:0]         mem_byteenable,
    output logic                                     mem_chipselect,
    output logic                                     mem_write,
    output logic [DATA_W-1:0]                        mem_writedata,
    output logic                                     mem_clken,
    input  logic [DATA_W-1:0]                        mem_readdata
);
    import sd_card_mem_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || MEM_DEPTH > (2 ** ADDR_W)) begin : g_bad_cfg
        $error("sd_card_mem_arbiter: unsupported NUM_REQ/ADDR_W/MEM_DEPTH");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d, owner_q, owner_d, win;
    logic [NUM_REQ-1:0] req_any, grant, rvalid_d;
    logic               grant_vld, accept, addr_oor;
    logic               rd_pend_q, rd_pend_d, rd_blank_q, rd_blank_d;
    logic               cs_d, we_d;
    logic [ADDR_W-1:0]  win_addr, addr_d;
    logic [BE_W-1:0]    be_d;
    logic [DATA_W-1:0]  wdata_d, rdata_d;

    assign req_any = req_read | req_write;

    sd_card_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (req_any),
        .last_grant (last_q),
        .grant      (grant),
        .valid      (grant_vld)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win = IDX_W'(i);
            end
        end
    end

    // The winner is released in the same cycle it is sampled into the mem_* registers
    assign accept          = (state_q == IDLE) && grant_vld;
    assign req_waitrequest = accept ? ~grant : '1;
    assign win_addr        = req_address[int'(win)*ADDR_W +: ADDR_W];

`ifdef SD_MEM_RANGE_CHECK_EN
    assign addr_oor = 32'(win_addr) >= MEM_DEPTH;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_error <= '0;
        end else begin
            req_error <= (accept && addr_oor) ? grant : '0;
        end
    end
`else
    assign addr_oor = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        rd_pend_d  = rd_pend_q;
        rd_blank_d = rd_blank_q;
        addr_d     = mem_address;
        be_d       = mem_byteenable;
        wdata_d    = mem_writedata;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        rdata_d    = req_readdata;
        rvalid_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    addr_d     = win_addr;
                    be_d       = req_byteenable[int'(win)*BE_W +: BE_W];
                    wdata_d    = req_writedata[int'(win)*DATA_W +: DATA_W];
                    cs_d       = !addr_oor;
                    we_d       = req_write[win] && !addr_oor;
                    rd_pend_d  = !req_write[win];
                    rd_blank_d = addr_oor;
                    owner_d    = win;
                    last_d     = win;
                    state_d    = CMD;
                end
            end
            CMD: state_d = rd_pend_q ? RD : IDLE;
            RD: begin
                rdata_d           = rd_blank_q ? DATA_W'(RANGE_ERR_DATA) : mem_readdata;
                rvalid_d[owner_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            last_q            <= IDX_W'(NUM_REQ - 1);
            owner_q           <= '0;
            rd_pend_q         <= 1'b0;
            rd_blank_q        <= 1'b0;
            mem_address       <= '0;
            mem_byteenable    <= '0;
            mem_writedata     <= '0;
            mem_chipselect    <= 1'b0;
            mem_write         <= 1'b0;
            mem_clken         <= 1'b0;
            req_readdata      <= '0;
            req_readdatavalid <= '0;
        end else begin
            state_q           <= state_d;
            last_q            <= last_d;
            owner_q           <= owner_d;
            rd_pend_q         <= rd_pend_d;
            rd_blank_q        <= rd_blank_d;
            mem_address       <= addr_d;
            mem_byteenable    <= be_d;
            mem_writedata     <= wdata_d;
            mem_chipselect    <= cs_d;
            mem_write         <= we_d;
            mem_clken         <= 1'b1;
            req_readdata      <= rdata_d;
            req_readdatavalid <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_sd_card_mem_arbiter.sv
// Scoreboard bench for sd_card_mem_arbiter with a behavioural one-cycle-latency RAM.
// Define SD_MEM_RANGE_CHECK_EN to also cover the address range check.
module tb_sd_card_mem_arbiter;
    localparam int unsigned NR    = 2;
    localparam int unsigned AW    = 17;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 75000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR*AW-1:0]  req_address;
    logic [NR*4-1:0]   req_byteenable;
    logic [NR-1:0]     req_read;
    logic [NR-1:0]     req_write;
    logic [NR*DW-1:0]  req_writedata;
    logic [NR-1:0]     req_waitrequest;
    logic [DW-1:0]     req_readdata;
    logic [NR-1:0]     req_readdatavalid;
`ifdef SD_MEM_RANGE_CHECK_EN
    logic [NR-1:0]     req_error;
`endif
    logic [AW-1:0]     mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DW-1:0]     mem_writedata;
    logic              mem_clken;
    logic [DW-1:0]     mem_readdata;

    sd_card_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_address       (req_address),
        .req_byteenable    (req_byteenable),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_writedata     (req_writedata),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
`ifdef SD_MEM_RANGE_CHECK_EN
        .req_error         (req_error),
`endif
        .mem_address       (mem_address),
        .mem_byteenable    (mem_byteenable),
        .mem_chipselect    (mem_chipselect),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_clken         (mem_clken),
        .mem_readdata      (mem_readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          acc_id[$];
    int          acc_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          vcount[NR];
    logic [31:0] ref_mem[int];

    // Behavioural RAM: address sampled on the edge, q valid the following cycle
    logic [31:0] ram [0:DEPTH-1];
    logic [AW-1:0] ram_addr_q = '0;
    logic        pre_we = 1'b0;
    int          pre_addr = 0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) ram[pre_addr] <= pre_data;
        if (mem_clken && mem_chipselect) begin
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            ram_addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    task automatic preload(input int a, input logic [31:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (req_readdatavalid[i]) begin
                    vcount[i]++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_valid req=%0d data=%h cyc=%0d", i, req_readdata, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.id !== i || e.data !== req_readdata || e.cyc !== cyc) begin
                            errors++;
                            $display("FAIL read_return got req=%0d data=%h cyc=%0d exp req=%0d data=%h cyc=%0d",
                                     i, req_readdata, cyc, e.id, e.data, e.cyc);
                        end
                    end
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic do_access(input int id, input bit rd, input logic [AW-1:0] addr,
                             input logic [3:0] be, input logic [31:0] data);
        int t;
        logic [31:0] ed;
        req_address[id*AW +: AW]   = addr;
        req_byteenable[id*4 +: 4]  = be;
        req_writedata[id*DW +: DW] = data;
        req_read[id]  = rd;
        req_write[id] = !rd;
        #1;
        t = 0;
        while (req_waitrequest[id] && t < 30) begin
            @(posedge clk); #2;
            t++;
        end
        checks++;
        if (req_waitrequest[id]) begin
            errors++;
            $display("FAIL accept_timeout req=%0d waitrequest=1 required 0", id);
        end else begin
            acc_id.push_back(id);
            acc_cyc.push_back(cyc);
            if (rd) begin
                ed = (int'(addr) < int'(DEPTH)) ? ref_mem[int'(addr)] : 32'h0;
                sb.push_back('{id, ed, cyc + 3});
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[int'(addr)][8*b +: 8] = data[8*b +: 8];
            end
        end
        @(posedge clk); #1;
        req_read[id]  = 1'b0;
        req_write[id] = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_waitrequest !== 2'b11) begin errors++; $display("FAIL rst_waitreq got %b exp 11", req_waitrequest); end
        checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rst_cs_we got %b%b exp 00", mem_chipselect, mem_write); end
        checks++; if (mem_address !== '0 || mem_byteenable !== '0 || mem_writedata !== '0) begin errors++; $display("FAIL rst_mem_bus got %h %b %h exp 0", mem_address, mem_byteenable, mem_writedata); end
        checks++; if (mem_clken !== 1'b0) begin errors++; $display("FAIL rst_clken got %b exp 0", mem_clken); end
        checks++; if (req_readdatavalid !== '0 || req_readdata !== '0) begin errors++; $display("FAIL rst_rdata got %b %h exp 0", req_readdatavalid, req_readdata); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL clken_after_release got %b exp 1", mem_clken); end
    endtask

    task automatic test_single_read();
        int c0;
        preload(5, 32'h1234_5678);
        c0 = cyc;
        do_access(0, 1'b1, 17'd5, 4'hF, 32'h0);
        checks++; if (acc_cyc[$] !== c0) begin errors++; $display("FAIL rd_accept_cycle got %0d exp %0d", acc_cyc[$], c0); end
        checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== 17'd5) begin
            errors++; $display("FAIL rd_cmd got cs=%b we=%b addr=%0d exp 1 0 5", mem_chipselect, mem_write, mem_address); end
        wait_drain();
        checks++; if (vcount[0] !== 1) begin errors++; $display("FAIL rd_valid_count got %0d exp 1", vcount[0]); end
    endtask

    task automatic test_write_readback();
        preload(100, 32'hAAAA_AAAA);
        do_access(1, 1'b0, 17'd100, 4'b0011, 32'hCAFE_F00D);
        checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 || mem_address !== 17'd100 ||
                      mem_byteenable !== 4'b0011 || mem_writedata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL wr_cmd got cs=%b we=%b addr=%0d be=%b wd=%h", mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata); end
        do_access(1, 1'b1, 17'd100, 4'hF, 32'h0);
        wait_drain();
        checks++; if (ram[100] !== 32'hAAAA_F00D) begin errors++; $display("FAIL wr_ram_contents got %h exp aaaaf00d", ram[100]); end
        do_access(1, 1'b0, 17'd100, 4'b0000, 32'hFFFF_FFFF);
        do_access(1, 1'b1, 17'd100, 4'hF, 32'h0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            preload(200 + k, 32'h2000_0000 + k);
            preload(300 + k, 32'h3000_0000 + k);
        end
        acc_id.delete(); acc_cyc.delete();
        fork
            for (int k = 0; k < 3; k++) do_access(0, 1'b1, 17'(200 + k), 4'hF, 32'h0);
            for (int k = 0; k < 3; k++) do_access(1, 1'b1, 17'(300 + k), 4'hF, 32'h0);
        join
        wait_drain();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (acc_id[k] !== k % 2 || (k > 0 && acc_cyc[k] - acc_cyc[k-1] !== 3)) begin
                errors++; $display("FAIL b2b_grant k=%0d got req=%0d gap=%0d exp req=%0d gap=3",
                                   k, acc_id[k], (k > 0) ? acc_cyc[k] - acc_cyc[k-1] : 3, k % 2);
            end
        end
    endtask

    task automatic test_same_cycle();
        preload(7, 32'h1);
        acc_id.delete(); acc_cyc.delete();
        fork
            do_access(0, 1'b1, 17'd7, 4'hF, 32'h0);
            do_access(1, 1'b0, 17'd7, 4'hF, 32'h2);
            begin
                #2;
                checks++; if (req_waitrequest !== 2'b10) begin errors++; $display("FAIL same_cycle_waitreq got %b exp 10", req_waitrequest); end
            end
        join
        do_access(0, 1'b1, 17'd7, 4'hF, 32'h0);
        wait_drain();
        checks++; if (acc_id[0] !== 0 || acc_id[1] !== 1) begin errors++; $display("FAIL same_cycle_order got %0d,%0d exp 0,1", acc_id[0], acc_id[1]); end
    endtask

    task automatic test_reset_mid_read();
        int v0;
        preload(9, 32'h5555_0009);
        preload(11, 32'h5555_0011);
        do_access(0, 1'b1, 17'd9, 4'hF, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        sb.delete();
        v0 = vcount[0] + vcount[1];
        checks++; if (req_waitrequest !== 2'b11 || mem_chipselect !== 1'b0 || mem_clken !== 1'b0 ||
                      req_readdatavalid !== '0 || req_readdata !== '0) begin
            errors++; $display("FAIL midrst_outputs got wr=%b cs=%b ck=%b v=%b rd=%h", req_waitrequest, mem_chipselect, mem_clken, req_readdatavalid, req_readdata); end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++; if (vcount[0] + vcount[1] !== v0) begin errors++; $display("FAIL midrst_no_valid got %0d exp %0d", vcount[0] + vcount[1], v0); end
        acc_id.delete(); acc_cyc.delete();
        fork
            do_access(1, 1'b1, 17'd11, 4'hF, 32'h0);
            do_access(0, 1'b1, 17'd9, 4'hF, 32'h0);
        join
        wait_drain();
        checks++; if (acc_id[0] !== 0) begin errors++; $display("FAIL midrst_first_grant got %0d exp 0", acc_id[0]); end
    endtask

`ifdef SD_MEM_RANGE_CHECK_EN
    task automatic test_range();
        do_access(0, 1'b1, 17'd75000, 4'hF, 32'h0);
        checks++; if (mem_chipselect !== 1'b0 || req_error !== 2'b01) begin
            errors++; $display("FAIL range_t1 got cs=%b err=%b exp 0 01", mem_chipselect, req_error); end
        @(posedge clk); #1;
        checks++; if (mem_chipselect !== 1'b0 || req_error !== 2'b00) begin
            errors++; $display("FAIL range_t2 got cs=%b err=%b exp 0 00", mem_chipselect, req_error); end
        wait_drain();
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        req_address = '0; req_byteenable = '0; req_read = '0; req_write = '0; req_writedata = '0;
        for (int i = 0; i < NR; i++) vcount[i] = 0;
        fork monitor(); join_none
        test_reset();
        test_single_read();
        test_write_readback();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid_read();
`ifdef SD_MEM_RANGE_CHECK_EN
        test_range();
`endif
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
